decoder_nto2n_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder, successor to the 2-to-4 gate-level decoder. Generalises address width to N. Adds an enable, a valid/ready load handshake for direct decode, and an autonomous scan mode that walks the outputs with programmable dwell. Used as a row/channel select driver: direct addressing from a controller, or free-running scan for multiplexed displays and sensor arrays.

---
 rtl/decoder_nto2n_seq.sv | 85 ++++++++
 tb/tb_decoder_nto2n_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with direct (valid/ready) addressing
// and an autonomous scan mode that walks the outputs with a programmable dwell.
module decoder_nto2n_seq #(
    parameter int N     = 2,
    parameter int DIV_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        addr,
    input  logic [DIV_W-1:0]    div,
    output logic [(1<<N)-1:0]   y,
    output logic                y_valid,
    output logic [N-1:0]        cur_addr,
    output logic                wrap
);

    localparam int W = 1 << N;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic [W-1:0]     Y_ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     ADDR_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    // Handshake: a transfer happens on a rising edge where in_valid & in_ready.
    // in_ready is purely en & ~mode and never looks at in_valid.
    logic [1:0]       state;
    logic [DIV_W-1:0] cnt;
    logic [N-1:0]     next_addr;

    assign in_ready  = en & ~mode;
    assign next_addr = cur_addr + ADDR_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            y        <= '0;
            y_valid  <= 1'b0;
            cur_addr <= '0;
            wrap     <= 1'b0;
            cnt      <= '0;
        end else if (!en) begin
            // cur_addr deliberately keeps its last value while disabled
            state   <= ST_IDLE;
            y       <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
            cnt     <= '0;
        end else if (mode) begin
            if (state != ST_SCAN) begin
                state    <= ST_SCAN;
                y        <= Y_ONE;
                cur_addr <= '0;
                y_valid  <= 1'b1;
                cnt      <= div;
                wrap     <= 1'b0;
            end else if (cnt != '0) begin
                cnt  <= cnt - CNT_ONE;
                wrap <= 1'b0;
            end else begin
                // div is only sampled here, so mid-dwell changes wait for reload
                cur_addr <= next_addr;
                y        <= Y_ONE << next_addr;
                cnt      <= div;
                wrap     <= &cur_addr;
            end
        end else begin
            state <= ST_DIRECT;
            cnt   <= '0;
            wrap  <= 1'b0;
            if (in_valid) begin
                y        <= Y_ONE << addr;
                cur_addr <= addr;
                y_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench: an N=2 and an N=3 decoder share stimulus and are
// compared each cycle against an index/dwell reference model.
module tb_decoder_nto2n_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, in_valid;
    logic [2:0] addr;
    logic [7:0] div;

    logic       in_ready2, y_valid2, wrap2;
    logic [3:0] y2;
    logic [1:0] cur_addr2;
    logic       in_ready3, y_valid3, wrap3;
    logic [7:0] y3;
    logic [2:0] cur_addr3;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, one slot per instance (0: N=2, 1: N=3)
    int m_idx[2], m_left[2];
    bit m_val[2], m_scan[2], m_wrap[2];
    int m_size[2] = '{4, 8};

    always #5 clk = ~clk;

    decoder_nto2n_seq #(.N(2), .DIV_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready2), .addr(addr[1:0]), .div(div), .y(y2),
        .y_valid(y_valid2), .cur_addr(cur_addr2), .wrap(wrap2)
    );

    decoder_nto2n_seq #(.N(3), .DIV_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready3), .addr(addr), .div(div), .y(y3),
        .y_valid(y_valid3), .cur_addr(cur_addr3), .wrap(wrap3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_idx[i] = 0; m_left[i] = 0; m_val[i] = 0; m_scan[i] = 0; m_wrap[i] = 0;
        end
    endtask

    // One clock edge of behaviour, computed from the selection rules directly
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 0;
            if (!en) begin
                m_scan[i] = 0; m_val[i] = 0; m_left[i] = 0;
            end else if (mode) begin
                if (!m_scan[i]) begin
                    m_scan[i] = 1; m_idx[i] = 0; m_val[i] = 1; m_left[i] = int'(div);
                end else if (m_left[i] > 0) begin
                    m_left[i]--;
                end else begin
                    m_wrap[i] = (m_idx[i] == m_size[i] - 1);
                    m_idx[i]  = (m_idx[i] + 1) % m_size[i];
                    m_left[i] = int'(div);
                end
            end else begin
                m_scan[i] = 0;
                if (in_valid) begin
                    m_idx[i] = int'(addr) % m_size[i];
                    m_val[i] = 1;
                end
            end
        end
    endtask

    function automatic logic [63:0] exp_y(input int i);
        return m_val[i] ? (64'd1 << m_idx[i]) : 64'd0;
    endfunction

    task automatic check_outputs();
        check("n2.y",        64'(y2),        exp_y(0));
        check("n2.y_valid",  64'(y_valid2),  64'(m_val[0]));
        check("n2.cur_addr", 64'(cur_addr2), 64'(m_idx[0]));
        check("n2.wrap",     64'(wrap2),     64'(m_wrap[0]));
        check("n3.y",        64'(y3),        exp_y(1));
        check("n3.y_valid",  64'(y_valid3),  64'(m_val[1]));
        check("n3.cur_addr", 64'(cur_addr3), 64'(m_idx[1]));
        check("n3.wrap",     64'(wrap3),     64'(m_wrap[1]));
        check("n3.onehot0",  64'($onehot0(y3)), 64'd1);
    endtask

    task automatic drive(input logic e, input logic m, input logic v,
                         input logic [2:0] a, input logic [7:0] d);
        en = e; mode = m; in_valid = v; addr = a; div = d;
        #1;
        check("n2.in_ready", 64'(in_ready2), 64'(e & ~m));
        check("n3.in_ready", 64'(in_ready3), 64'(e & ~m));
    endtask

    // Inputs are changed just after a negedge; the edge is modelled and outputs checked at the next negedge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 0; mode = 0; in_valid = 0; addr = 0; div = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Direct decode, back-to-back transfers, then hold
        for (int a = 0; a < 4; a++) begin
            drive(1, 0, 1, 3'(a), 8'd0);
            step(1);
        end
        drive(1, 0, 0, 3'd1, 8'd0);
        step(3);

        // Scan with div=2 and stray in_valid pulses
        for (int k = 0; k < 30; k++) begin
            drive(1, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'd2);
            step(1);
        end

        // Dwell reload: div=0 then 3 mid-sweep
        drive(0, 0, 0, 3'd0, 8'd0);
        step(1);
        drive(1, 1, 0, 3'd0, 8'd0);
        step(10);
        drive(1, 1, 0, 3'd0, 8'd3);
        step(14);

        // Mode/enable transitions
        drive(1, 0, 0, 3'd0, 8'd0);
        step(3);
        drive(1, 0, 1, 3'd1, 8'd0);
        step(1);
        drive(0, 0, 0, 3'd1, 8'd0);
        step(2);
        drive(1, 1, 0, 3'd0, 8'd1);
        step(20);

        // Asynchronous reset while y shows index 2
        drive(1, 0, 1, 3'd2, 8'd0);
        step(1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        rst_n = 1'b1;
        drive(1, 1, 0, 3'd0, 8'd1);
        step(40);

        // Randomised mix of all modes
        for (int k = 0; k < 600; k++) begin
            logic       e, m, v;
            logic [7:0] d;
            e = ($urandom_range(0, 19) != 0);
            m = ($urandom_range(0, 24) == 0) ? ~mode : mode;
            v = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : div;
            drive(e, m, v, 3'($urandom_range(0, 7)), d);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
